// File: rtl/unit_sincos_pl.sv
// ---------------------------------------------------------------------------
// unit_sincos_pl
//
// Piecewise-linear quarter-wave evaluator. One phase word in, a cos and a sin
// magnitude/sign pair out. This block feeds the Box-Muller stage of the AWGN
// generator: it sits between the uniform RNG phase output and the
// multiply-by-radius stage.
//
// The phase is split into a quadrant q (top 2 bits) and an in-quadrant
// position a. Its mirror is b = ~a. Both a and b are evaluated against a
// shared segment table:
//   f(x) = c0[seg] - ((c1[seg] * off) >> OFF_W)
// The result clamps to 0 instead of wrapping below zero. The quadrant then
// decides which of f(a), f(b) becomes cos and which becomes sin, and sets
// the sign.
//
// Pipeline (one sample per cycle, latency 3):
//   S1  table read (two synchronous read ports), register q and offsets
//   S2  two multiplies, shifted products registered
//   S3  subtract, clamp, quadrant select into the output registers
// The whole pipeline advances on en = !out_valid | out_ready.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   in_valid   phase word offered
//   in_ready   phase word accepted this cycle when in_valid is also high
//   u          phase word [IN_W-1:0]
//   out_valid  result pair is held on the outputs
//   out_ready  downstream takes the result
//   cos_mag    cos magnitude [OUT_W-1:0]; cos_sign is 1 when negative
//   sin_mag    sin magnitude [OUT_W-1:0]; sin_sign is 1 when negative
//   cfg_we     table write strobe (accepted every cycle, even during a stall)
//   cfg_addr   table entry [SEG_BITS-1:0]
//   cfg_c0     intercept [C0_W-1:0]
//   cfg_c1     slope [C1_W-1:0]
//
// OFF_W = IN_W-2-SEG_BITS must be at least 1, and C0_W must be at least
// OUT_W.
// ---------------------------------------------------------------------------
module unit_sincos_pl #(
  parameter int IN_W     = 16,
  parameter int SEG_BITS = 7,
  parameter int C0_W     = 19,
  parameter int C1_W     = 12,
  parameter int OUT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     u,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    cos_mag,
  output logic [OUT_W-1:0]    sin_mag,
  output logic                cos_sign,
  output logic                sin_sign,
  input  logic                cfg_we,
  input  logic [SEG_BITS-1:0] cfg_addr,
  input  logic [C0_W-1:0]     cfg_c0,
  input  logic [C1_W-1:0]     cfg_c1
);

  localparam int A_W    = IN_W - 2;
  localparam int OFF_W  = A_W - SEG_BITS;
  localparam int PROD_W = C1_W + OFF_W;
  localparam int ENT_W  = C0_W + C1_W;
  localparam int DEPTH  = 1 << SEG_BITS;
  // Common width for the clamp compare and the subtraction, so that a slope
  // wider than the intercept still compares correctly.
  localparam int CW     = (C0_W > C1_W) ? C0_W : C1_W;
  localparam int DROP   = C0_W - OUT_W;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic en;
  logic accept;
  logic started_reg;
  logic out_valid_reg;

  assign en        = !out_valid_reg | out_ready;
  // started_reg keeps in_ready low until the first clock after reset release.
  assign in_ready  = en & started_reg;
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_reg;

  // -------------------------------------------------------------------------
  // Phase split. Channel 0 evaluates a, channel 1 evaluates the mirror b = ~a.
  // -------------------------------------------------------------------------
  logic [1:0]          q_in;
  logic [A_W-1:0]      x_in   [2];
  logic [SEG_BITS-1:0] seg_in [2];
  logic [OFF_W-1:0]    off_in [2];

  assign q_in    = u[IN_W-1 -: 2];
  assign x_in[0] = u[A_W-1:0];
  assign x_in[1] = ~u[A_W-1:0];

  for (genvar gi = 0; gi < 2; gi++) begin : g_split
    assign seg_in[gi] = x_in[gi][A_W-1 -: SEG_BITS];
    assign off_in[gi] = x_in[gi][OFF_W-1:0];
  end

  // -------------------------------------------------------------------------
  // Coefficient table: one write port, two registered read ports.
  // The contents are not reset. A read of an entry that is written in the
  // same cycle returns the old data, because both updates are non-blocking.
  // The read registers advance only on en, so a write during a stall cannot
  // disturb a sample that S1 has already read.
  // -------------------------------------------------------------------------
  logic [ENT_W-1:0] mem    [DEPTH];
  logic [ENT_W-1:0] rd_reg [2];

  always_ff @(posedge clk) begin
    if (cfg_we) begin
      mem[cfg_addr] <= {cfg_c0, cfg_c1};
    end
    if (en) begin
      rd_reg[0] <= mem[seg_in[0]];
      rd_reg[1] <= mem[seg_in[1]];
    end
  end

  // -------------------------------------------------------------------------
  // Stage registers
  // -------------------------------------------------------------------------
  logic             v1_reg;
  logic [1:0]       q1_reg;
  logic [OFF_W-1:0] off1_reg [2];

  logic             v2_reg;
  logic [1:0]       q2_reg;
  logic [C0_W-1:0]  c0_2_reg [2];
  logic [C1_W-1:0]  sh2_reg  [2];

  logic [OUT_W-1:0] cos_mag_reg;
  logic [OUT_W-1:0] sin_mag_reg;
  logic             cos_sign_reg;
  logic             sin_sign_reg;

  // -------------------------------------------------------------------------
  // Per-channel datapath (S2 multiply, S3 subtract and clamp)
  // -------------------------------------------------------------------------
  logic [C0_W-1:0]   c0_rd     [2];
  logic [C1_W-1:0]   c1_rd     [2];
  logic [PROD_W-1:0] prod_next [2];
  logic [CW-1:0]     c0_ext    [2];
  logic [CW-1:0]     sh_ext    [2];
  logic [CW-1:0]     diff      [2];
  logic              clamp     [2];
  logic [OUT_W-1:0]  mag       [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    assign c0_rd[gi] = rd_reg[gi][ENT_W-1 -: C0_W];
    assign c1_rd[gi] = rd_reg[gi][C1_W-1:0];

    // The product width is exact, so the multiply never overflows.
    assign prod_next[gi] = PROD_W'(c1_rd[gi]) * PROD_W'(off1_reg[gi]);

    assign c0_ext[gi] = CW'(c0_2_reg[gi]);
    assign sh_ext[gi] = CW'(sh2_reg[gi]);
    assign clamp[gi]  = sh_ext[gi] > c0_ext[gi];
    assign diff[gi]   = c0_ext[gi] - sh_ext[gi];
    // The magnitude is the top OUT_W bits of the C0_W-bit result (truncated).
    assign mag[gi]    = clamp[gi] ? '0 : OUT_W'(diff[gi] >> DROP);
  end

  // -------------------------------------------------------------------------
  // Pipeline advance. All stages move together on en. When S3 sees a bubble,
  // it clears out_valid and leaves the last result on the data outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      started_reg   <= 1'b0;
      v1_reg        <= 1'b0;
      q1_reg        <= '0;
      v2_reg        <= 1'b0;
      q2_reg        <= '0;
      for (int i = 0; i < 2; i++) begin
        off1_reg[i] <= '0;
        c0_2_reg[i] <= '0;
        sh2_reg[i]  <= '0;
      end
      out_valid_reg <= 1'b0;
      cos_mag_reg   <= '0;
      sin_mag_reg   <= '0;
      cos_sign_reg  <= 1'b0;
      sin_sign_reg  <= 1'b0;
    end else begin
      started_reg <= 1'b1;
      if (en) begin
        // S1
        v1_reg <= accept;
        q1_reg <= q_in;
        for (int i = 0; i < 2; i++) begin
          off1_reg[i] <= off_in[i];
        end
        // S2
        v2_reg <= v1_reg;
        q2_reg <= q1_reg;
        for (int i = 0; i < 2; i++) begin
          c0_2_reg[i] <= c0_rd[i];
          sh2_reg[i]  <= C1_W'(prod_next[i] >> OFF_W);
        end
        // S3: odd quadrants take cos from a and sin from the mirror.
        // Quadrants 2 and 3 are negative for both outputs.
        out_valid_reg <= v2_reg;
        if (v2_reg) begin
          cos_mag_reg  <= q2_reg[0] ? mag[0] : mag[1];
          sin_mag_reg  <= q2_reg[0] ? mag[1] : mag[0];
          cos_sign_reg <= q2_reg[1];
          sin_sign_reg <= q2_reg[1];
        end
      end
    end
  end

  assign cos_mag  = cos_mag_reg;
  assign sin_mag  = sin_mag_reg;
  assign cos_sign = cos_sign_reg;
  assign sin_sign = sin_sign_reg;

endmodule

// File: tb/tb_unit_sincos_pl.sv
// ---------------------------------------------------------------------------
// tb_unit_sincos_pl
//
// Bench for unit_sincos_pl with the default parameters.
// A reference model evaluates the quarter-wave formula with plain integer
// arithmetic on a mirror copy of the coefficient table. Each accepted phase
// pushes its expected result into a queue. Each delivered result pops one
// entry and compares it.
// Hand tables and short sequences cover the fixed corner cases.
// ---------------------------------------------------------------------------
module tb_unit_sincos_pl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] u;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] cos_mag;
  logic [15:0] sin_mag;
  logic        cos_sign;
  logic        sin_sign;
  logic        cfg_we;
  logic [6:0]  cfg_addr;
  logic [18:0] cfg_c0;
  logic [11:0] cfg_c1;

  unit_sincos_pl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .u         (u),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cos_mag   (cos_mag),
    .sin_mag   (sin_mag),
    .cos_sign  (cos_sign),
    .sin_sign  (sin_sign),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_c0    (cfg_c0),
    .cfg_c1    (cfg_c1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1);
  end

  // -------------------------------------------------------------------------
  // Bookkeeping and reference model
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;
  int n_deliv  = 0;

  int unsigned tc0 [128];
  int unsigned tc1 [128];
  logic [33:0] sb [$];

  logic        hold_prev = 1'b0;
  logic [33:0] hold_val  = '0;

  logic [18:0] cur_c0 = '0;
  logic [11:0] cur_c1 = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One segment evaluation on a 14-bit position: 128 segments of 128 steps.
  // The result is scaled from 19 to 16 bits.
  function automatic int unsigned fpl(input int unsigned x);
    int unsigned seg, off, sh;
    seg = x / 128;
    off = x % 128;
    sh  = (tc1[seg] * off) / 128;
    if (sh > tc0[seg]) return 0;
    return (tc0[seg] - sh) / 8;
  endfunction

  // Returns {cos_sign, cos_mag, sin_sign, sin_mag}.
  function automatic logic [33:0] model(input logic [15:0] uu);
    int unsigned a, b, fa, fb;
    logic [15:0] cm, sm;
    logic        neg;
    a   = uu % 16384;
    b   = 16383 - a;
    fa  = fpl(a);
    fb  = fpl(b);
    neg = uu[15];
    case (uu / 16384)
      0:       begin cm = 16'(fb); sm = 16'(fa); end
      1:       begin cm = 16'(fa); sm = 16'(fb); end
      2:       begin cm = 16'(fb); sm = 16'(fa); end
      default: begin cm = 16'(fa); sm = 16'(fb); end
    endcase
    return {neg, cm, neg, sm};
  endfunction

  // -------------------------------------------------------------------------
  // One clock cycle. Inputs are set at posedge+1. The task lets them settle,
  // records the handshakes, updates the model table after any accepted read
  // (so that a read in the same cycle sees the old entry), then waits for the
  // next edge.
  // -------------------------------------------------------------------------
  task automatic tick();
    logic [33:0] got, exp;
    #1;
    got = {cos_sign, cos_mag, sin_sign, sin_mag};
    if (hold_prev) check("stall_hold", {out_valid, got}, {1'b1, hold_val});
    hold_prev = out_valid && !out_ready;
    hold_val  = got;
    if (in_valid && in_ready) sb.push_back(model(u));
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_out: got result 0x%0h with nothing pending", got);
      end else begin
        exp = sb.pop_front();
        check("result", 64'(got), 64'(exp));
        n_deliv++;
      end
    end
    if (cfg_we) begin
      tc0[cfg_addr] = cfg_c0;
      tc1[cfg_addr] = cfg_c1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_table(input logic [18:0] c0, input logic [11:0] c1);
    cfg_we = 1'b1;
    for (int i = 0; i < 128; i++) begin
      cfg_addr = 7'(i);
      cfg_c0   = c0;
      cfg_c1   = c1;
      tick();
    end
    cfg_we = 1'b0;
    cur_c0 = c0;
    cur_c1 = c1;
  endtask

  // Offer one phase into an empty pipe. Return the cycles to out_valid and
  // the result.
  task automatic run_single(input logic [15:0] uu, output int lat, output logic [33:0] got);
    in_valid  = 1'b1;
    u         = uu;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    got = {cos_sign, cos_mag, sin_sign, sin_mag};
    tick();
  endtask

  typedef struct {
    logic [18:0] c0;
    logic [11:0] c1;
    logic [15:0] u;
    logic        cs;
    logic [15:0] cm;
    logic        ss;
    logic [15:0] sm;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  logic [15:0] stall_u [8];

  initial begin
    int          lat;
    logic [33:0] got;
    int          sent;
    int          base;
    int          w;

    // Hand vectors. Table A is c0=0x40000, c1=0x100; table B is c0=0x10, c1=0xFFF.
    vecs[0] = '{19'h40000, 12'h100, 16'h4000, 1'b0, 16'h8000, 1'b0, 16'h7FE0};
    vecs[1] = '{19'h40000, 12'h100, 16'hC000, 1'b1, 16'h8000, 1'b1, 16'h7FE0};
    vecs[2] = '{19'h40000, 12'h100, 16'h8000, 1'b1, 16'h7FE0, 1'b1, 16'h8000};
    vecs[3] = '{19'h40000, 12'h100, 16'h0000, 1'b0, 16'h7FE0, 1'b0, 16'h8000};
    vecs[4] = '{19'h40000, 12'h100, 16'h6005, 1'b0, 16'h7FFE, 1'b0, 16'h7FE1};
    vecs[5] = '{19'h00010, 12'hFFF, 16'h007F, 1'b0, 16'h0002, 1'b0, 16'h0000};
    vecs[6] = '{19'h00010, 12'hFFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0002};
    vecs[7] = '{19'h00010, 12'hFFF, 16'h4001, 1'b0, 16'h0000, 1'b0, 16'h0000};

    for (int i = 0; i < 8; i++) stall_u[i] = 16'(16'h4000 + i * 16'h0913 + (i % 4) * 16'h4000);

    rst       = 1'b0;
    in_valid  = 1'b0;
    u         = '0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_c0    = '0;
    cfg_c1    = '0;

    // ---- reset state ----
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {in_ready, out_valid, cos_sign, cos_mag, sin_sign, sin_mag}, '0);
    rst = 1'b1;
    tick();
    check("ready_after_release", in_ready, 1'b1);

    // ---- table-driven vectors ----
    load_table(19'h40000, 12'h100);
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].c0 != cur_c0 || vecs[i].c1 != cur_c1) load_table(vecs[i].c0, vecs[i].c1);
      run_single(vecs[i].u, lat, got);
      check($sformatf("vec%0d_latency", i), lat, 3);
      check($sformatf("vec%0d_out", i), 64'(got), 64'({vecs[i].cs, vecs[i].cm, vecs[i].ss, vecs[i].sm}));
      $display("vec %0d u=0x%04h lat=%0d cos=%0d/0x%04h sin=%0d/0x%04h",
               i, vecs[i].u, lat, got[33], got[32:17], got[16], got[15:0]);
    end

    // ---- table write in the same cycle as the read of that entry ----
    load_table(19'h40000, 12'h100);
    cfg_we    = 1'b1;
    cfg_addr  = 7'd0;
    cfg_c0    = 19'h20000;
    cfg_c1    = 12'h100;
    in_valid  = 1'b1;
    u         = 16'h4000;
    out_ready = 1'b1;
    tick();
    cfg_we = 1'b0;
    tick();
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 10) begin
      tick();
      w++;
    end
    check("coll_old_data", cos_mag, 16'h8000);
    tick();
    check("coll_new_valid", out_valid, 1'b1);
    check("coll_new_data", cos_mag, 16'h4000);
    repeat (3) tick();
    cfg_we   = 1'b1;
    cfg_addr = 7'd0;
    cfg_c0   = 19'h40000;
    tick();
    cfg_we = 1'b0;

    // ---- 8 back-to-back phases, out_ready low in cycles 4..6 ----
    base = n_deliv;
    sent = 0;
    for (int c = 0; c < 40 && (n_deliv - base) < 8; c++) begin
      in_valid  = (sent < 8);
      u         = stall_u[sent % 8];
      out_ready = !(c >= 4 && c <= 6);
      #1;
      if (c >= 4 && c <= 6) check($sformatf("stall_in_ready_c%0d", c), in_ready, 1'b0);
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stall_sent", sent, 8);
    check("stall_delivered", n_deliv - base, 8);
    $display("stall stream: sent %0d delivered %0d", sent, n_deliv - base);

    // ---- random table and stream against the model ----
    cfg_we = 1'b1;
    for (int i = 0; i < 128; i++) begin
      cfg_addr = 7'(i);
      cfg_c0   = (i % 4 == 0) ? 19'($urandom_range(0, 4095)) : 19'($urandom);
      cfg_c1   = 12'($urandom);
      tick();
    end
    cfg_we = 1'b0;
    base = n_deliv;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      u         = 16'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 15) == 0);
      cfg_addr  = 7'($urandom);
      cfg_c0    = 19'($urandom);
      cfg_c1    = 12'($urandom);
      tick();
    end
    in_valid  = 1'b0;
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    w = 0;
    while (sb.size() > 0 && w < 20) begin
      tick();
      w++;
    end
    check("random_drain_empty", sb.size(), 0);
    $display("random stream: delivered %0d results", n_deliv - base);

    // ---- reset with samples in flight ----
    load_table(19'h40000, 12'h100);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    u = 16'h4000; tick();
    u = 16'hC000; tick();
    u = 16'h8000; tick();
    in_valid = 1'b0;
    check("pre_reset_valid", out_valid, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_reset_outputs", {out_valid, cos_sign, cos_mag, sin_sign, sin_mag}, '0);
    sb.delete();
    hold_prev = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("held_reset_valid", out_valid, 1'b0);
    rst = 1'b1;
    tick();
    check("ready_after_mid_release", in_ready, 1'b1);
    run_single(16'h4000, lat, got);
    check("post_reset_latency", lat, 3);
    check("post_reset_out", 64'(got), 64'({1'b0, 16'h8000, 1'b0, 16'h7FE0}));
    $display("post reset u=0x4000 lat=%0d cos=0x%04h sin=0x%04h", lat, got[32:17], got[15:0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/unit_sincos_pl.md
# unit_sincos_pl

Parametrised piecewise-linear quarter-wave evaluator producing cos and sin magnitude/sign pairs from one phase word, for the Box-Muller stage of the AWGN generator. It replaces the fixed-width cos unit: widths and segment count are parameters, the coefficient table is a runtime-writable dual-read RAM, and a valid/ready handshake with full-pipeline back-pressure is added. The block sits between the uniform RNG phase output and the multiply-by-radius stage.

## Interface
- IN_W, 16, phase word width; top 2 bits are the quadrant.
- SEG_BITS, 7, segment index bits; OFF_W = IN_W-2-SEG_BITS (derived, must be ≥1).
- C0_W, 19, intercept coefficient width (unsigned).
- C1_W, 12, slope coefficient width (unsigned).
- OUT_W, 16, output magnitude width; C0_W ≥ OUT_W.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  phase word offered.
- in_ready  out  1  block accepts phase this cycle.
- u  in  IN_W  phase word.
- out_valid  out  1  result pair held on outputs.
- out_ready  in  1  downstream accepts result.
- cos_mag / sin_mag  out  OUT_W each  magnitudes.
- cos_sign / sin_sign  out  1 each  1 = negative.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  SEG_BITS  table entry.
- cfg_c0  in  C0_W;  cfg_c1  in  C1_W  entry data.

## Operation
- Split: q = u[IN_W-1:IN_W-2]; a = u[IN_W-3:0]; b = bitwise NOT a (= 2^(IN_W-2)-1-a).
- For x ∈ {a,b}: seg = x[top SEG_BITS], off = x[low OFF_W]; f(x) = c0[seg] − ((c1[seg]·off) >> OFF_W); product width C1_W+OFF_W, exact.
- Clamp: if the shifted product > c0, f = 0 (no wrap).
- Magnitude = f[C0_W-1 : C0_W-OUT_W] (truncate).
- Selection: q=0 cos=f(b)+, sin=f(a)+; q=1 cos=f(a)+, sin=f(b)+; q=2 cos=f(b)−, sin=f(a)−; q=3 cos=f(a)−, sin=f(b)−.
- Table: 2^SEG_BITS entries {c0,c1}, two synchronous read ports (seg_a, seg_b), one write port. Contents not reset; undefined until written.
- Write and read of the same entry in the same cycle: read returns old data; new data visible to reads issued the next cycle.

## Timing
- Pipeline: S1 table read + register q/off_a/off_b; S2 two multiplies registered; S3 subtract, clamp, select into output registers.
- Latency: accepted phase (in_valid & in_ready) to out_valid = 3 cycles; throughput 1 per cycle.
- Advance enable en = !out_valid | out_ready; in_ready = en (combinational). When en=0 all stages, including table read registers, hold; no sample dropped or duplicated.
- Bubbles propagate as stage valid bits = 0; outputs hold last value while out_valid=0.
- Outputs stable while out_valid=1 and out_ready=0.
- cfg writes are accepted every cycle regardless of en; writes during a stall do not alter data already read into S1.
- Reset (any time, including mid-stream): all stage valids, out_valid, magnitudes, signs → 0; in_ready → 1 one cycle after release; in-flight samples discarded; table contents retained.

## Test plan
- Load all entries c0=0x40000, c1=0x100; u=0x4000 → after 3 cycles cos_mag=0x8000, cos_sign=0, sin_mag=0x7FE0, sin_sign=0.
- Same table, u=0xC000 → cos_mag=0x8000, sin_mag=0x7FE0, both signs 1; u=0x8000 → cos_mag=0x7FE0, sin_mag=0x8000, signs 1.
- All entries c0=0x10, c1=0xFFF; u=0x007F → sin_mag=0x0000 (clamped), cos_mag=0x0002, signs 0.
- Stream 8 phases back-to-back with out_ready low for cycles 4–6 → in_ready low those cycles, outputs frozen, all 8 results delivered in order, none lost or repeated.
- Write entry 0 to c0=0x20000 in the same cycle as u=0x4000 accepted → result uses old entry (0x8000); next phase u=0x4000 → cos_mag=0x4000.
- Assert rst with 2 samples in flight → out_valid=0, outputs 0 immediately; after release next phase returns correct values with 3-cycle latency and table unchanged.
